controle_rodada: RTL and testbench

- Round sequencer for the score datapath: requests a target line, waits for the player's press, judges hit/miss/timeout, and issues single-cycle acertou/errou pulses to the score counter.
- Enforces line blocking from the score counter's linhas_bloq and terminates the game on win (pontos reaches META_PONTOS) or loss (MAX_ERROS total misses).
- Sits between the button debouncer / random target source and the score counter, in the top-level game datapath.

---
 rtl/controle_rodada_pkg.sv | 57 +++++
 rtl/controle_rodada_contador_timeout.sv | 43 ++++
 rtl/controle_rodada.sv | 186 ++++++++++++++++++
 tb/tb_controle_rodada.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_rodada_pkg.sv
// controle_rodada_pkg
//   Shared definitions for the round sequencer: state encoding (also exported
//   on db_estado), default game parameters, line count and small helpers used
//   for press decoding and register sizing.
package controle_rodada_pkg;

  localparam int unsigned NUM_LINHAS         = 8;
  localparam int unsigned TIMEOUT_CICLOS_PAD = 1000;
  localparam int unsigned META_PONTOS_PAD    = 32;
  localparam int unsigned MAX_ERROS_PAD      = 5;

  typedef enum logic [3:0] {
    INICIAL       = 4'd0,
    PREPARA       = 4'd1,
    PEDE_ALVO     = 4'd2,
    ESPERA_ALVO   = 4'd3,
    LIBERA        = 4'd4,
    ESPERA_JOGADA = 4'd5,
    ACERTO        = 4'd6,
    ERRO          = 4'd7,
    AVALIA        = 4'd8,
    FIM           = 4'd9
  } estado_t;

  // Number of buttons pressed in a jogada word.
  function automatic logic [3:0] conta_bits(input logic [NUM_LINHAS-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int unsigned i = 0; i < NUM_LINHAS; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  // Index of the highest set bit; only meaningful when exactly one bit is set.
  function automatic logic [2:0] indice_bit(input logic [NUM_LINHAS-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_LINHAS; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned largura_timer(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to hold 0..n, never less than three.
  function automatic int unsigned largura_erros(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 1);
    return (w > 3) ? w : 3;
  endfunction

endpackage

// File: rtl/controle_rodada_contador_timeout.sv
// contador_timeout
//   Up-counter measuring how long the player has been waited on.
//   Ports:
//     clk_i  - clock, rising edge
//     rst_i  - synchronous active-high reset
//     clr_i  - synchronous clear (wins over en_i)
//     en_i   - count enable; the count holds once the terminal value is reached
//     fim_o  - high while the count equals LIMITE-1
module contador_timeout #(
  parameter int unsigned LIMITE  = 1000,
  parameter int unsigned LARGURA = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic fim_o
);

  localparam logic [LARGURA-1:0] ULTIMO = LARGURA'(LIMITE - 1);

  logic [LARGURA-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !fim_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fim_o = (cnt_q == ULTIMO);

endmodule

// File: rtl/controle_rodada.sv
// controle_rodada
//   Round sequencer of the game datapath. Requests a target line, waits for
//   the player's press, judges hit / miss / timeout and sends one-cycle
//   acertou / errou pulses to the score counter. Lines below linhas_bloq are
//   blocked, both as targets and as presses. The game ends on reaching
//   META_PONTOS (win) or MAX_ERROS misses (loss).
//   Ports:
//     clock, reset           - clock and synchronous active-high reset
//     iniciar                - start request (INICIAL and FIM)
//     jogada[7:0]            - one-hot debounced buttons
//     alvo[2:0], alvo_valido - target from the random source
//     pontos[5:0]            - current score
//     linhas_bloq[2:0]       - number of blocked lines, counted from line 0
//     pede_alvo              - one-cycle request for a new target
//     acertou, errou         - one-cycle hit / miss pulses (registered)
//     enable_pontos          - score counter enable while a game is running
//     linha_ativa[2:0]       - current target
//     espera                 - waiting for the player's press
//     fim_jogo, ganhou       - game over and its result
//     db_estado[3:0]         - current state encoding
module controle_rodada
  import controle_rodada_pkg::*;
#(
  parameter int unsigned TIMEOUT_CICLOS = TIMEOUT_CICLOS_PAD,
  parameter int unsigned META_PONTOS    = META_PONTOS_PAD,
  parameter int unsigned MAX_ERROS      = MAX_ERROS_PAD
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  iniciar,
  input  logic [NUM_LINHAS-1:0] jogada,
  input  logic [2:0]            alvo,
  input  logic                  alvo_valido,
  input  logic [5:0]            pontos,
  input  logic [2:0]            linhas_bloq,
  output logic                  pede_alvo,
  output logic                  acertou,
  output logic                  errou,
  output logic                  enable_pontos,
  output logic [2:0]            linha_ativa,
  output logic                  espera,
  output logic                  fim_jogo,
  output logic                  ganhou,
  output logic [3:0]            db_estado
);

  localparam int unsigned LARG_TIMER = largura_timer(TIMEOUT_CICLOS);
  localparam int unsigned LARG_ERROS = largura_erros(MAX_ERROS);
  localparam logic [LARG_ERROS-1:0] ERROS_LIM = LARG_ERROS'(MAX_ERROS);

  estado_t               estado_q, estado_d;
  logic [2:0]            linha_q, linha_d;
  logic [LARG_ERROS-1:0] erros_q, erros_d;
  logic                  ganhou_q, ganhou_d;

  logic pede_q, acertou_q, errou_q, enable_q, espera_q, fim_q;

  // Press decode
  logic [3:0]            n_bits;
  logic [2:0]            idx_tecla;
  logic [NUM_LINHAS-1:0] alvo_onehot;
  logic                  tecla_unica, tecla_multipla, tecla_bloqueada, tecla_certa;
  logic                  timeout;

  always_comb begin
    n_bits                 = conta_bits(jogada);
    idx_tecla              = indice_bit(jogada);
    alvo_onehot            = '0;
    alvo_onehot[linha_q]   = 1'b1;
    tecla_unica            = (n_bits == 4'd1);
    tecla_multipla         = (n_bits > 4'd1);
    tecla_bloqueada        = tecla_unica && (idx_tecla < linhas_bloq);
    tecla_certa            = (jogada == alvo_onehot);
  end

  // The timer is held clear outside ESPERA_JOGADA, so it always starts from
  // zero on the first waiting cycle.
  contador_timeout #(
    .LIMITE  (TIMEOUT_CICLOS),
    .LARGURA (LARG_TIMER)
  ) u_timer (
    .clk_i (clock),
    .rst_i (reset),
    .clr_i (estado_q != ESPERA_JOGADA),
    .en_i  (estado_q == ESPERA_JOGADA),
    .fim_o (timeout)
  );

  always_comb begin
    estado_d = estado_q;
    linha_d  = linha_q;
    erros_d  = erros_q;
    ganhou_d = ganhou_q;

    unique case (estado_q)
      INICIAL, FIM: begin
        // Per-game state is cleared on the way into PREPARA so that it
        // already reads zero while PREPARA is active.
        if (iniciar) begin
          estado_d = PREPARA;
          linha_d  = '0;
          erros_d  = '0;
          ganhou_d = 1'b0;
        end
      end
      PREPARA:     estado_d = PEDE_ALVO;
      PEDE_ALVO:   estado_d = ESPERA_ALVO;
      ESPERA_ALVO: begin
        if (alvo_valido) begin
          if (alvo < linhas_bloq) begin
            estado_d = PEDE_ALVO;
          end else begin
            linha_d  = alvo;
            estado_d = LIBERA;
          end
        end
      end
      LIBERA: begin
        if (jogada == '0) estado_d = ESPERA_JOGADA;
      end
      ESPERA_JOGADA: begin
        if (tecla_multipla)       estado_d = ERRO;
        else if (tecla_bloqueada) estado_d = ESPERA_JOGADA;
        else if (tecla_certa)     estado_d = ACERTO;
        else if (tecla_unica)     estado_d = ERRO;
        else if (timeout)         estado_d = ERRO;
      end
      ACERTO: estado_d = AVALIA;
      ERRO: begin
        if (erros_q < ERROS_LIM) erros_d = erros_q + 1'b1;
        estado_d = AVALIA;
      end
      AVALIA: begin
        if (32'(pontos) >= META_PONTOS) begin
          estado_d = FIM;
          ganhou_d = 1'b1;
        end else if (erros_q == ERROS_LIM) begin
          estado_d = FIM;
          ganhou_d = 1'b0;
        end else begin
          estado_d = PEDE_ALVO;
        end
      end
      default: estado_d = INICIAL;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each one is
  // valid for exactly the cycles its state is current and is glitch-free.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= INICIAL;
      linha_q   <= '0;
      erros_q   <= '0;
      ganhou_q  <= 1'b0;
      pede_q    <= 1'b0;
      acertou_q <= 1'b0;
      errou_q   <= 1'b0;
      enable_q  <= 1'b0;
      espera_q  <= 1'b0;
      fim_q     <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      linha_q   <= linha_d;
      erros_q   <= erros_d;
      ganhou_q  <= ganhou_d;
      pede_q    <= (estado_d == PEDE_ALVO);
      acertou_q <= (estado_d == ACERTO);
      errou_q   <= (estado_d == ERRO);
      enable_q  <= (estado_d != INICIAL) && (estado_d != FIM);
      espera_q  <= (estado_d == ESPERA_JOGADA);
      fim_q     <= (estado_d == FIM);
    end
  end

  assign pede_alvo     = pede_q;
  assign acertou       = acertou_q;
  assign errou         = errou_q;
  assign enable_pontos = enable_q;
  assign linha_ativa   = linha_q;
  assign espera        = espera_q;
  assign fim_jogo      = fim_q;
  assign ganhou        = ganhou_q;
  assign db_estado     = estado_q;

endmodule

// File: tb/tb_controle_rodada.sv
module tb_controle_rodada;

  localparam int T_OUT = 10;
  localparam int META  = 32;
  localparam int MAXE  = 5;

  localparam int HIT = 0, WRONG = 1, MULTI = 2, TMO = 3;
  localparam int C_HIT = 0, C_ERR = 1, C_IGN = 2;

  logic       clock = 1'b0;
  logic       reset, iniciar, alvo_valido;
  logic [7:0] jogada;
  logic [2:0] alvo, linhas_bloq;
  logic [5:0] pontos;
  logic       pede_alvo, acertou, errou, enable_pontos, espera, fim_jogo, ganhou;
  logic [2:0] linha_ativa;
  logic [3:0] db_estado;

  int n_chk = 0;
  int n_pass = 0;

  // Game-level reference model
  int score, misses;
  bit ended;

  controle_rodada #(
    .TIMEOUT_CICLOS (T_OUT),
    .META_PONTOS    (META),
    .MAX_ERROS      (MAXE)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .iniciar       (iniciar),
    .jogada        (jogada),
    .alvo          (alvo),
    .alvo_valido   (alvo_valido),
    .pontos        (pontos),
    .linhas_bloq   (linhas_bloq),
    .pede_alvo     (pede_alvo),
    .acertou       (acertou),
    .errou         (errou),
    .enable_pontos (enable_pontos),
    .linha_ativa   (linha_ativa),
    .espera        (espera),
    .fim_jogo      (fim_jogo),
    .ganhou        (ganhou),
    .db_estado     (db_estado)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Judgement of one press from the rules of the game
  function automatic int classifica(input logic [7:0] p, input int alvo_v, input int bloq);
    int idx;
    idx = 0;
    if ($countones(p) > 1) return C_ERR;
    for (int i = 0; i < 8; i++) if (p[i]) idx = i;
    if (idx < bloq) return C_IGN;
    if (idx == alvo_v) return C_HIT;
    return C_ERR;
  endfunction

  task automatic inicia_jogo();
    jogada      = '0;
    alvo_valido = 1'b0;
    pontos      = '0;
    score       = 0;
    misses      = 0;
    ended       = 0;
    iniciar     = 1'b1;
    tick();
    chk("prepara_estado", 32'(db_estado), 1);
    chk("prepara_enable", 32'(enable_pontos), 1);
    chk("prepara_fim", 32'(fim_jogo), 0);
    iniciar = 1'b0;
    tick();
    chk("pede_inicial", 32'(pede_alvo), 1);
    chk("linha_limpa", 32'(linha_ativa), 0);
  endtask

  // One round, entered while pede_alvo is high.
  task automatic rodada(input int bloq, input int alvo_v, input int n_ofertas, input int n_ign,
                        input int acao, input logic [7:0] tecla, input bit segurar, input int incr);
    int         wcyc, idx, i2;
    logic [7:0] p;
    bit         exp_hit;
    linhas_bloq = 3'(bloq);
    for (int k = 0; k < n_ofertas; k++) begin
      alvo = 3'($urandom_range(bloq - 1, 0));
      alvo_valido = 1'b1;
      tick();
      chk("pede_pulso_unico", 32'(pede_alvo), 0);
      tick();
      chk("repede_bloqueado", 32'(pede_alvo), 1);
      chk("sem_pulso_bloq", 32'(acertou | errou), 0);
    end
    alvo = 3'(alvo_v);
    alvo_valido = 1'b1;
    tick();
    chk("pede_pulso_unico", 32'(pede_alvo), 0);
    tick();
    alvo_valido = 1'b0;
    chk("linha_ativa", 32'(linha_ativa), 32'(alvo_v));
    chk("libera_sem_espera", 32'(espera), 0);
    if (jogada != '0) begin
      for (int k = 0; k < int'($urandom_range(3, 1)); k++) begin
        tick();
        chk("libera_segura", 32'(espera), 0);
        chk("libera_sem_pulso", 32'(acertou | errou), 0);
      end
      jogada = '0;
    end
    tick();
    chk("entra_espera", 32'(espera), 1);
    wcyc = 1;
    for (int k = 0; k < n_ign; k++) begin
      idx = int'($urandom_range(bloq - 1, 0));
      p = 8'b1 << idx;
      jogada = p;
      tick();
      wcyc++;
      chk("ignora_classe", 32'(classifica(p, alvo_v, bloq)), C_IGN);
      chk("ignora_espera", 32'(espera), 1);
      chk("ignora_pulso", 32'(acertou | errou), 0);
      jogada = '0;
      tick();
      wcyc++;
      chk("ignora_solta", 32'(espera), 1);
    end
    if (acao == TMO) begin
      while (wcyc < T_OUT) begin
        tick();
        wcyc++;
        chk("aguarda_espera", 32'(espera), 1);
        chk("aguarda_sem_erro", 32'(errou), 0);
      end
      exp_hit = 0;
      tick();
    end else begin
      if (tecla != '0) p = tecla;
      else if (acao == HIT) p = 8'b1 << alvo_v;
      else if (acao == WRONG) begin
        do idx = int'($urandom_range(7, bloq)); while (idx == alvo_v);
        p = 8'b1 << idx;
      end else begin
        idx = int'($urandom_range(7, 0));
        i2  = (idx + int'($urandom_range(7, 1))) % 8;
        p = (8'b1 << idx) | (8'b1 << i2);
      end
      exp_hit = (classifica(p, alvo_v, bloq) == C_HIT);
      jogada = p;
      tick();
    end
    chk("acertou", 32'(acertou), 32'(exp_hit));
    chk("errou", 32'(errou), 32'(!exp_hit));
    chk("sai_espera", 32'(espera), 0);
    if (exp_hit) score = (score + incr > 63) ? 63 : score + incr;
    else misses++;
    pontos = 6'(score);
    if (!segurar) jogada = '0;
    tick();
    chk("pulso_unico", 32'(acertou | errou), 0);
    tick();
    if (score >= META) begin
      ended = 1;
      chk("fim_vitoria", 32'(fim_jogo), 1);
      chk("ganhou_1", 32'(ganhou), 1);
      chk("fim_enable", 32'(enable_pontos), 0);
    end else if (misses >= MAXE) begin
      ended = 1;
      chk("fim_derrota", 32'(fim_jogo), 1);
      chk("ganhou_0", 32'(ganhou), 0);
      chk("fim_enable", 32'(enable_pontos), 0);
    end else begin
      chk("proxima_pede", 32'(pede_alvo), 1);
      chk("continua", 32'(fim_jogo), 0);
    end
  endtask

  initial begin
    int b, a;
    reset = 1'b1; iniciar = 1'b0; alvo_valido = 1'b0; jogada = '0;
    alvo = '0; linhas_bloq = '0; pontos = '0;
    tick();
    tick();
    chk("rst_estado", 32'(db_estado), 0);
    chk("rst_pede", 32'(pede_alvo), 0);
    chk("rst_pulsos", 32'(acertou | errou), 0);
    chk("rst_enable", 32'(enable_pontos), 0);
    chk("rst_espera", 32'(espera), 0);
    chk("rst_fim", 32'(fim_jogo | ganhou), 0);
    chk("rst_linha", 32'(linha_ativa), 0);
    reset = 1'b0;
    tick();
    chk("inicial_parado", 32'(db_estado), 0);

    // Game 1: directed rounds ending in a loss
    inicia_jogo();
    rodada(0, 3, 0, 0, HIT,   8'b00001000, 0, 1);
    rodada(2, 5, 1, 1, HIT,   8'h00,       0, 1);
    rodada(0, 4, 0, 0, TMO,   8'h00,       0, 1);
    rodada(0, 4, 0, 0, MULTI, 8'b00110000, 0, 1);
    rodada(0, 6, 0, 0, WRONG, 8'b00000100, 0, 1);
    rodada(1, 2, 1, 0, WRONG, 8'h00,       0, 1);
    rodada(0, 7, 0, 0, TMO,   8'h00,       0, 1);
    chk("jogo1_terminou", 32'(ended), 1);

    // Game 2: restart from FIM, held button, four misses, then a win
    inicia_jogo();
    rodada(0, 1, 0, 0, HIT,   8'h00, 1, 5);
    rodada(3, 6, 2, 2, WRONG, 8'h00, 0, 1);
    rodada(1, 3, 0, 1, TMO,   8'h00, 0, 1);
    rodada(2, 7, 1, 0, MULTI, 8'h00, 0, 1);
    rodada(0, 0, 0, 0, WRONG, 8'h00, 0, 1);
    rodada(0, 5, 0, 0, HIT,   8'h00, 0, 27);
    chk("jogo2_terminou", 32'(ended), 1);

    // Game 3: randomized rounds
    inicia_jogo();
    for (int r = 0; r < 100 && !ended; r++) begin
      b = int'($urandom_range(3, 0));
      a = int'($urandom_range(7, b));
      rodada(b, a, (b > 0) ? int'($urandom_range(2, 0)) : 0,
             (b > 0) ? int'($urandom_range(2, 0)) : 0,
             int'($urandom_range(3, 0)), 8'h00, bit'($urandom_range(1, 0)),
             int'($urandom_range(10, 1)));
    end
    chk("jogo3_terminou", 32'(ended), 1);

    // Reset while waiting for a press
    inicia_jogo();
    linhas_bloq = '0;
    alvo = 3'd2;
    alvo_valido = 1'b1;
    tick();
    tick();
    alvo_valido = 1'b0;
    tick();
    chk("rst_pre_espera", 32'(espera), 1);
    reset = 1'b1;
    tick();
    chk("rst_meio_estado", 32'(db_estado), 0);
    chk("rst_meio_espera", 32'(espera), 0);
    chk("rst_meio_enable", 32'(enable_pontos), 0);
    chk("rst_meio_linha", 32'(linha_ativa), 0);
    reset = 1'b0;
    tick();
    chk("rst_meio_inicial", 32'(db_estado), 0);

    // Reset during an acertou pulse
    inicia_jogo();
    alvo = 3'd2;
    alvo_valido = 1'b1;
    tick();
    tick();
    alvo_valido = 1'b0;
    tick();
    jogada = 8'b00000100;
    tick();
    chk("pulso_antes_rst", 32'(acertou), 1);
    reset = 1'b1;
    jogada = '0;
    tick();
    chk("rst_pulso", 32'(acertou | errou), 0);
    chk("rst_pulso_estado", 32'(db_estado), 0);
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
